// File: rtl/cpu_jtag_debug_cmd_sync.sv
// cpu_jtag_debug_cmd_sync: sysclk-side JTAG debug command receiver with toggle sync, startup mask and FWFT command FIFO
// Ports: udr_tgl/uir_tgl TCK toggles; ir_in/sr quasi-static TCK data; cmd_* valid/ready FIFO head;
// ir_cur/ir_update last Update-IR value and pulse; fifo_level, sticky overflow/parity_err cleared by err_clr.
// Optional JTAG_CMD_PARITY_EN: drop commands whose sr has odd parity and flag parity_err.
module cpu_jtag_debug_cmd_sync #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                udr_tgl,
  input  logic                uir_tgl,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [SR_WIDTH-1:0] sr,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [IR_WIDTH-1:0] cmd_ir,
  output logic [SR_WIDTH-1:0] cmd_data,
  output logic [IR_WIDTH-1:0] ir_cur,
  output logic                ir_update,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                overflow,
  output logic                parity_err,
  input  logic                err_clr
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int MW = $clog2(SYNC_STAGES + 2);
  localparam int EW = IR_WIDTH + SR_WIDTH;
  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_hist_q, uir_hist_q;
  logic [MW-1:0]          mask_cnt_q, mask_cnt_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   valid_q, valid_d;
  logic [EW-1:0]          head_q, head_d;
  logic [IR_WIDTH-1:0]    ir_cur_q, ir_cur_d;
  logic                   ir_upd_q, ir_upd_d;
  logic                   ovf_q, ovf_d, par_q, par_d;
  logic                   masked, udr_edge, uir_edge, par_ok, udr_ok, full, pop, push, rem_empty;
  `ifdef JTAG_CMD_PARITY_EN
  assign par_ok = ~^sr;
  `else
  assign par_ok = 1'b1;
  `endif
  always_comb begin
    masked     = mask_cnt_q != MW'(SYNC_STAGES + 1);
    mask_cnt_d = masked ? mask_cnt_q + MW'(1) : mask_cnt_q;
    udr_edge   = !masked & (udr_sync_q[SYNC_STAGES-1] ^ udr_hist_q);
    uir_edge   = !masked & (uir_sync_q[SYNC_STAGES-1] ^ uir_hist_q);
    full       = level_q == LVL_W'(FIFO_DEPTH);
    pop        = valid_q & cmd_ready;
    udr_ok     = udr_edge & par_ok;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    push       = udr_ok & (!full | pop);
    level_d    = (push & !pop) ? level_q + LVL_W'(1) : (!push & pop) ? level_q - LVL_W'(1) : level_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    // when no older entry survives this cycle the new head comes straight from the inputs
    rem_empty  = level_q == LVL_W'(pop);
    head_d     = rem_empty ? (push ? {ir_in, sr} : head_q) : mem_q[rd_ptr_d];
    valid_d    = level_d != '0;
    ir_cur_d   = uir_edge ? ir_in : ir_cur_q;
    ir_upd_d   = uir_edge;
    // a new error outranks err_clr in the same cycle
    ovf_d      = (udr_ok & full & !pop) | (ovf_q & !err_clr);
    par_d      = (udr_edge & !par_ok) | (par_q & !err_clr);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_hist_q <= 1'b0;
      uir_hist_q <= 1'b0;
      mask_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      ir_cur_q   <= '0;
      ir_upd_q   <= 1'b0;
      ovf_q      <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], udr_tgl};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], uir_tgl};
      // history always follows the synced level, so masked edges are absorbed rather than deferred
      udr_hist_q <= udr_sync_q[SYNC_STAGES-1];
      uir_hist_q <= uir_sync_q[SYNC_STAGES-1];
      mask_cnt_q <= mask_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      ir_cur_q   <= ir_cur_d;
      ir_upd_q   <= ir_upd_d;
      ovf_q      <= ovf_d;
      par_q      <= par_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ir_in, sr};
  end
  assign cmd_valid  = valid_q;
  assign cmd_ir     = head_q[EW-1:SR_WIDTH];
  assign cmd_data   = head_q[SR_WIDTH-1:0];
  assign ir_cur     = ir_cur_q;
  assign ir_update  = ir_upd_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign parity_err = par_q;
endmodule

// File: tb/tb_cpu_jtag_debug_cmd_sync.sv
// tb_cpu_jtag_debug_cmd_sync: table-driven and scoreboard checks of the JTAG debug command receiver
module tb_cpu_jtag_debug_cmd_sync;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset, udr_tgl, uir_tgl, cmd_ready, err_clr;
  logic [1:0]  ir_in, cmd_ir, ir_cur;
  logic [37:0] sr, cmd_data;
  logic        cmd_valid, ir_update, overflow, parity_err;
  logic [2:0]  fifo_level;
  int          n_chk = 0, n_fail = 0;
  logic [39:0] q[$];
  typedef struct {logic [37:0] d; logic [1:0] ir; int lvl; logic ovf;} vec_t;
  vec_t tbl[5];
  cpu_jtag_debug_cmd_sync dut (
    .clk(clk), .reset(reset), .udr_tgl(udr_tgl), .uir_tgl(uir_tgl), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .ir_cur(ir_cur), .ir_update(ir_update), .fifo_level(fifo_level), .overflow(overflow),
    .parity_err(parity_err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [37:0] mk(input logic [37:0] v);
    `ifdef JTAG_CMD_PARITY_EN
    return {^v[36:0], v[36:0]};
    `else
    return v;
    `endif
  endfunction
  task automatic do_udr(input logic [37:0] d, input logic [1:0] ir);
    sr = d;
    ir_in = ir;
    udr_tgl = ~udr_tgl;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("udr_latency_lvl", 64'(fifo_level), 64'(q.size()));
    @(posedge clk);
    @(negedge clk);
    if (q.size() < DEPTH) q.push_back({ir, d});
  endtask
  task automatic pop_chk(input string nm);
    logic [39:0] e;
    e = q.pop_front();
    cmd_ready = 1'b1;
    chk({nm, "_valid"}, 64'(cmd_valid), 64'd1);
    chk({nm, "_data"}, 64'(cmd_data), 64'(e[37:0]));
    chk({nm, "_ir"}, 64'(cmd_ir), 64'(e[39:38]));
    @(posedge clk);
    @(negedge clk);
    cmd_ready = 1'b0;
    chk({nm, "_lvl"}, 64'(fifo_level), 64'(q.size()));
  endtask
  initial begin
    int pulses;
    logic bad;
    tbl[0] = '{mk(38'd1), 2'd0, 1, 1'b0};
    tbl[1] = '{mk(38'd2), 2'd1, 2, 1'b0};
    tbl[2] = '{mk(38'd3), 2'd2, 3, 1'b0};
    tbl[3] = '{mk(38'd4), 2'd3, 4, 1'b0};
    tbl[4] = '{mk(38'd5), 2'd0, 4, 1'b1};
    reset = 1'b1; udr_tgl = 0; uir_tgl = 0; cmd_ready = 0; err_clr = 0; ir_in = 0; sr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(cmd_valid), 0);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_data", 64'(cmd_data), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    do_udr(mk(38'h15_5555_5555), 2'b01);
    chk("t1_valid", 64'(cmd_valid), 1);
    chk("t1_level", 64'(fifo_level), 1);
    pop_chk("t1_pop");
    chk("t1_valid_after", 64'(cmd_valid), 0);
    foreach (tbl[i]) begin
      do_udr(tbl[i].d, tbl[i].ir);
      chk($sformatf("fill%0d_lvl", i), 64'(fifo_level), 64'(tbl[i].lvl));
      chk($sformatf("fill%0d_ovf", i), 64'(overflow), 64'(tbl[i].ovf));
    end
    for (int i = 0; i < 4; i++) pop_chk($sformatf("drain%0d", i));
    chk("ovf_sticky", 64'(overflow), 1);
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovf_cleared", 64'(overflow), 0);
    for (int i = 0; i < 4; i++) do_udr(mk(38'(10 + i)), 2'(i));
    chk("full_lvl", 64'(fifo_level), 4);
    sr = mk(38'd14);
    ir_in = 2'd2;
    udr_tgl = ~udr_tgl;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_ready = 1'b1;
    chk("fullpop_head", 64'(cmd_data), 64'(q[0][37:0]));
    @(posedge clk);
    @(negedge clk);
    cmd_ready = 1'b0;
    void'(q.pop_front());
    q.push_back({2'd2, mk(38'd14)});
    chk("fullpop_lvl", 64'(fifo_level), 4);
    chk("fullpop_ovf", 64'(overflow), 0);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("order%0d", i));
    reset = 1'b1; udr_tgl = 1'b1; uir_tgl = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      bad |= cmd_valid | ir_update;
    end
    chk("mask_no_events", 64'(bad), 0);
    ir_in = 2'b10;
    uir_tgl = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      pulses += int'(ir_update);
    end
    chk("uir_pulses", 64'(pulses), 1);
    chk("uir_cur", 64'(ir_cur), 2);
    for (int i = 0; i < 3; i++) do_udr(mk(38'(20 + i)), 2'd1);
    sr = mk(38'd30);
    udr_tgl = ~udr_tgl;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(cmd_valid), 0);
    chk("arst_level", 64'(fifo_level), 0);
    chk("arst_data", 64'(cmd_data), 0);
    chk("arst_ircur", 64'(ir_cur), 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      bad |= cmd_valid | (fifo_level != 0);
    end
    chk("arst_no_stale", 64'(bad), 0);
    sr = 38'h1;
    udr_tgl = ~udr_tgl;
    repeat (3) @(posedge clk);
    @(negedge clk);
    `ifdef JTAG_CMD_PARITY_EN
    chk("par1_lvl", 64'(fifo_level), 0);
    chk("par1_err", 64'(parity_err), 1);
    `else
    q.push_back({ir_in, 38'h1});
    chk("par1_lvl", 64'(fifo_level), 1);
    chk("par1_err", 64'(parity_err), 0);
    `endif
    do_udr(38'h3, ir_in);
    chk("par3_lvl", 64'(fifo_level), 64'(q.size()));
    while (q.size() > 0) pop_chk("par_pop");
    chk("par_ovf", 64'(overflow), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_jtag_debug_cmd_sync.md
Name: cpu_jtag_debug_cmd_sync

Overview:
System-clock-side receiver for the Nios II JTAG debug path. It takes Update-DR and Update-IR toggles from the TCK domain, synchronises them, and captures the quasi-static shift register and IR into a parametrised command FIFO. Commands are presented to the OCI/break/trace decode logic via a valid/ready handshake. It supersedes the fixed-width, unbuffered sysclk capture by adding width/depth parameters, buffering, backpressure, overflow reporting and startup edge masking.

Parameters:
SR_WIDTH, 38, width of the captured data register (sr, cmd_data)
IR_WIDTH, 2, width of the virtual JTAG IR
SYNC_STAGES, 2, synchroniser flop count per toggle; legal values are 2 or more
FIFO_DEPTH, 4, command FIFO entries; power of 2, 2 or more
LVL_W, $clog2(FIFO_DEPTH)+1, derived; width of the level output

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
udr_tgl  in  1  TCK-domain toggle; inverts once per Update-DR
uir_tgl  in  1  TCK-domain toggle; inverts once per Update-IR
ir_in  in  IR_WIDTH  TCK-domain IR; stable from the toggle until the next shift
sr  in  SR_WIDTH  TCK-domain data register; stable from the toggle until the next shift
cmd_valid  out  1  FIFO head valid
cmd_ready  in  1  consumer accepts the head
cmd_ir  out  IR_WIDTH  IR captured with the head command
cmd_data  out  SR_WIDTH  sr captured with the head command
ir_cur  out  IR_WIDTH  last IR value seen at an Update-IR
ir_update  out  1  one-cycle pulse when ir_cur is updated
fifo_level  out  LVL_W  number of entries, 0..FIFO_DEPTH
overflow  out  1  sticky: an Update-DR was dropped
parity_err  out  1  sticky: a command failed the parity check (see Optional Feature)
err_clr  in  1  clears overflow and parity_err

Behaviour:
- Reset is asynchronous, active-high, and may occur at any time. On reset:
  - all sync flops, edge-history flops, FIFO pointers and level are cleared
  - cmd_valid=0, cmd_ir=0, cmd_data=0, ir_cur=0, ir_update=0, fifo_level=0, overflow=0, parity_err=0
  - any in-flight command is discarded
- Synchronisers:
  - udr_tgl and uir_tgl each pass through SYNC_STAGES flops.
  - Edge = last sync stage XOR a history flop.
- Startup mask:
  - A counter masks edges for SYNC_STAGES+1 cycles after reset deassertion.
  - During the mask the history flop tracks the synced value, so a toggle that is already 1 at reset release produces no command.
- Update-DR edge:
  - {ir_in, sr} are sampled directly in the edge cycle; they are quasi-static by protocol.
  - The pair is pushed into the FIFO if not full.
  - If full and no pop occurs in the same cycle, the pair is dropped and overflow is set.
  - If full and a pop occurs in the same cycle, the push is accepted.
- Update-IR edge: in the edge cycle, ir_cur <= ir_in and ir_update=1 for exactly one cycle.
- Simultaneous UDR and UIR edges: both are processed in the same cycle. The pushed command carries the ir_in sampled in that cycle.
- Latency:
  - Count cycles from the first rising edge that samples the new toggle level.
  - The push, and the ir_cur/ir_update update, occur at edge SYNC_STAGES+1.
  - cmd_valid rises at that same edge when the FIFO was empty.
- FIFO behaviour:
  - First-word fall-through; cmd_ir/cmd_data are registered from the head entry.
  - Pop occurs when cmd_valid & cmd_ready; cmd_ready is ignored when empty.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level changes by +1 (push only), -1 (pop only), or 0 (both or neither).
- Sticky flags: err_clr clears overflow and parity_err. A new error in the same cycle as err_clr takes priority and the flag remains set.
- cmd_data/cmd_ir hold their last value when cmd_valid=0.

Optional Feature:
JTAG_CMD_PARITY_EN
- Defined:
  - A command is valid only if the XOR of all SR_WIDTH bits of sr is 0 (even parity); sr[SR_WIDTH-1] is the parity bit.
  - A failing command is not pushed and sets parity_err. overflow is not set for it.
  - The parity check is evaluated in the edge cycle.
- Undefined:
  - Every Update-DR is pushed.
  - parity_err is tied to 0; the port remains present.

Test Plan:
- Defaults, FIFO empty. Toggle udr_tgl 0->1 with sr=38'h15_5555_5555, ir_in=2'b01 -> cmd_valid high at sampling edge 3; cmd_data=38'h15_5555_5555, cmd_ir=1, fifo_level=1. Assert cmd_ready for 1 cycle -> cmd_valid=0, level=0.
- cmd_ready=0; 5 Update-DR toggles with sr=1..5 -> level saturates at 4 and overflow=1. Popping yields 1,2,3,4 in order. err_clr clears overflow.
- FIFO full, cmd_ready=1 held in the same cycle as a 5th push edge -> no overflow, level stays 4, data order preserved.
- udr_tgl=1 and uir_tgl=1 held through reset release -> no cmd_valid and no ir_update for 20 cycles. Then toggle uir_tgl with ir_in=2'b10 -> single ir_update pulse, ir_cur=2.
- Assert reset while 3 entries are queued and a toggle is in flight -> all outputs 0 immediately. After release, no stale command appears.
- With JTAG_CMD_PARITY_EN: sr=38'h1 -> dropped, parity_err=1, level unchanged. sr=38'h3 -> pushed. Without the macro, both are pushed and parity_err stays 0.
